// File: rtl/cla_pkg.sv
`default_nettype none
//============================================================================
// Module : cla_pkg
// Brief  : Shared constants and helpers for the pipelined CLA adder/subtractor
// Rev    : 1.0 - initial release
//============================================================================
package cla_pkg;

    localparam int   GROUP_W  = 4;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Subtraction runs as a + ~b + !borrow_in, so the borrow is inverted here.
    function automatic logic eff_carry(input logic cin, input logic mode);
        return (mode == MODE_SUB) ? ~cin : cin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
//============================================================================
// Module : cla_group4
// Brief  : 4-bit carry-lookahead group with group propagate/generate outputs
// Rev    : 1.0 - initial release
//============================================================================
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               cout,
    output logic               grp_p,
    output logic               grp_g
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign grp_p = &w_p;
    assign grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign cout  = grp_g | (grp_p & cin);
    assign s     = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
//============================================================================
// Module : pipelined_cla_addsub
// Brief  : Pipelined carry-lookahead adder/subtractor with valid/ready flow
// Rev    : 1.0 - initial release
//============================================================================
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int GRP_PER_STAGE = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int c_SW     = GROUP_W * GRP_PER_STAGE;
    localparam int c_STAGES = WIDTH / c_SW;

    logic             w_en;
    logic             r_vld [c_STAGES];
    logic [WIDTH-1:0] r_a   [c_STAGES];
    logic [WIDTH-1:0] r_b   [c_STAGES];
    logic [WIDTH-1:0] r_sum [c_STAGES];
    logic             r_c   [c_STAGES];
    logic             r_ovf;
    logic             r_zero;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        localparam int c_LSB = k * c_SW;

        logic                     w_vin;
        logic                     w_cin;
        logic [WIDTH-1:0]         w_a;
        logic [WIDTH-1:0]         w_b;
        logic [WIDTH-1:0]         w_sprev;
        logic [WIDTH-1:0]         w_snew;
        logic [GRP_PER_STAGE:0]   w_c;
        logic [GRP_PER_STAGE-1:0] w_gp;
        logic [GRP_PER_STAGE-1:0] w_gg;
        logic [GRP_PER_STAGE-1:0] w_co;
        logic [c_SW-1:0]          w_s;

        // b is inverted once at entry so later stages never need the mode.
        if (k == 0) begin : g_first
            assign w_vin   = in_valid;
            assign w_a     = in_a;
            assign w_b     = in_b ^ {WIDTH{in_sub == MODE_SUB}};
            assign w_cin   = eff_carry(in_cin, in_sub);
            assign w_sprev = '0;
        end else begin : g_next
            assign w_vin   = r_vld[k-1];
            assign w_a     = r_a[k-1];
            assign w_b     = r_b[k-1];
            assign w_cin   = r_c[k-1];
            assign w_sprev = r_sum[k-1];
        end

        assign w_c[0] = w_cin;

        for (genvar j = 0; j < GRP_PER_STAGE; j++) begin : g_grp
            cla_group4 u_grp (
                .a     (w_a[c_LSB + GROUP_W*j +: GROUP_W]),
                .b     (w_b[c_LSB + GROUP_W*j +: GROUP_W]),
                .cin   (w_c[j]),
                .s     (w_s[GROUP_W*j +: GROUP_W]),
                .cout  (w_co[j]),
                .grp_p (w_gp[j]),
                .grp_g (w_gg[j])
            );
            assign w_c[j+1] = w_gg[j] | (w_gp[j] & w_c[j]);
        end

        always_comb begin
            w_snew                = w_sprev;
            w_snew[c_LSB +: c_SW] = w_s;
        end

        // The inter-group chain must agree with each group's own carry-out.
        always @(posedge clk) begin
            assert (w_co == w_c[GRP_PER_STAGE:1]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end else if (w_en) begin
                r_vld[k] <= w_vin;
                r_a[k]   <= w_a;
                r_b[k]   <= w_b;
                r_sum[k] <= w_snew;
                r_c[k]   <= w_c[GRP_PER_STAGE];
            end
        end

        if (k == c_STAGES - 1) begin : g_last
            logic w_cmsb;
            assign w_cmsb = w_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_snew[WIDTH-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_en) begin
                    r_ovf  <= w_cmsb ^ w_c[GRP_PER_STAGE];
                    r_zero <= (w_snew == '0);
                end
            end
        end
    end

    assign out_valid = r_vld[c_STAGES-1];
    assign out_sum   = r_sum[c_STAGES-1];
    assign out_cout  = r_c[c_STAGES-1];
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
`default_nettype none
//============================================================================
// Module : tb_pipelined_cla_addsub
// Brief  : Scoreboard bench for a 16-bit/1-group and a 32-bit/2-group adder
// Rev    : 1.0 - initial release
//============================================================================
module tb_pipelined_cla_addsub;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        rsti [2];
    logic        ivi  [2];
    logic        cini [2];
    logic        subi [2];
    logic        ordy [2];
    logic [63:0] ai   [2];
    logic [63:0] bi   [2];

    logic        ov [2];
    logic        ir [2];
    logic        co [2];
    logic        of [2];
    logic        zo [2];
    logic [15:0] sum0;
    logic [31:0] sum1;
    logic [63:0] so [2];

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_pop [2];
    logic        lat_chk [2];
    logic        stall_prev [2];
    logic [63:0] held_sum [2];
    logic [63:0] last_sum [2];
    logic        last_cout [2];
    logic        last_ovf [2];
    logic        last_zero [2];

    assign so[0] = {48'd0, sum0};
    assign so[1] = {32'd0, sum1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_addsub #(.WIDTH(16), .GRP_PER_STAGE(1)) u_dut16 (
        .clk(clk), .rst(rsti[0]), .in_valid(ivi[0]), .in_ready(ir[0]),
        .in_a(ai[0][15:0]), .in_b(bi[0][15:0]), .in_cin(cini[0]), .in_sub(subi[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0),
        .out_cout(co[0]), .out_ovf(of[0]), .out_zero(zo[0])
    );

    pipelined_cla_addsub #(.WIDTH(32), .GRP_PER_STAGE(2)) u_dut32 (
        .clk(clk), .rst(rsti[1]), .in_valid(ivi[1]), .in_ready(ir[1]),
        .in_a(ai[1][31:0]), .in_b(bi[1][31:0]), .in_cin(cini[1]), .in_sub(subi[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1),
        .out_cout(co[1]), .out_ovf(of[1]), .out_zero(zo[1])
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic su);
        logic [63:0] m, am, be;
        logic [64:0] full;
        exp_t        e;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & m;
        be   = (su ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, be} + {64'd0, (su ? !ci : ci)};
        e.sum  = full[63:0] & m;
        e.cout = full[w];
        e.ovf  = (am[w-1] == be[w-1]) && (e.sum[w-1] != am[w-1]);
        e.zero = (e.sum == 64'd0);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 16 : 32;
    endfunction

    // One clock of stimulus; handshakes are judged at the negedge after inputs settle.
    task automatic step(input int d, input logic v, input logic [63:0] aa, input logic [63:0] bb,
                        input logic ci, input logic su, input logic ordy_i, input logic rs,
                        output logic acc);
        exp_t e;
        int   qs;
        @(negedge clk);
        if (stall_prev[d]) begin
            chk($sformatf("d%0d_stall_valid", d), 64'(ov[d]), 64'd1);
            chk($sformatf("d%0d_stall_sum", d), so[d], held_sum[d]);
        end
        rsti[d] = rs; ivi[d] = v; ai[d] = aa; bi[d] = bb;
        cini[d] = ci; subi[d] = su; ordy[d] = ordy_i;
        #1;
        stall_prev[d] = ov[d] && !ordy[d] && !rs;
        held_sum[d]   = so[d];
        acc = v && ir[d] && !rs;
        if (ov[d] && !ordy[d])
            chk($sformatf("d%0d_in_ready_stall", d), 64'(ir[d]), 64'd0);
        if (rs) begin
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            if (ov[d] && ordy[d]) begin
                qs = (d == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    chk($sformatf("d%0d_out_with_empty_queue", d), 64'(ov[d]), 64'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    n_pop[d]++;
                    chk($sformatf("d%0d_sum", d), so[d], e.sum);
                    chk($sformatf("d%0d_cout", d), 64'(co[d]), 64'(e.cout));
                    chk($sformatf("d%0d_ovf", d), 64'(of[d]), 64'(e.ovf));
                    chk($sformatf("d%0d_zero", d), 64'(zo[d]), 64'(e.zero));
                    if (lat_chk[d])
                        chk($sformatf("d%0d_latency", d), 64'(cyc - e.cyc), 64'd4);
                    last_sum[d] = so[d]; last_cout[d] = co[d];
                    last_ovf[d] = of[d]; last_zero[d] = zo[d];
                end
            end
            if (acc) begin
                e = model(width_of(d), aa, bb, ci, su);
                e.cyc = cyc;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic idle(input int d);
        logic got;
        step(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, got);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (n < 100 && (((d == 0) ? q0.size() : q1.size()) != 0 || ov[d])) begin
            idle(d);
            n++;
        end
        chk($sformatf("d%0d_drain_left", d), 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    task automatic reset_dut(input int d);
        logic got;
        for (int i = 0; i < 2; i++)
            step(d, 1'b1, 64'hDEAD, 64'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, got);
        idle(d);
        chk($sformatf("d%0d_rst_valid", d), 64'(ov[d]), 64'd0);
        chk($sformatf("d%0d_rst_sum", d), so[d], 64'd0);
        chk($sformatf("d%0d_rst_flags", d), {61'd0, co[d], of[d], zo[d]}, 64'd0);
        chk($sformatf("d%0d_rst_in_ready", d), 64'(ir[d]), 64'd1);
    endtask

    task automatic dir_test(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic ci, input logic su, input logic [63:0] xs,
                            input logic xc, input logic xo, input logic xz);
        logic got;
        step(0, 1'b1, a, b, ci, su, 1'b1, 1'b0, got);
        chk({tag, "_accepted"}, 64'(got), 64'd1);
        drain(0);
        chk({tag, "_sum"}, last_sum[0], xs);
        chk({tag, "_cout"}, 64'(last_cout[0]), 64'(xc));
        chk({tag, "_ovf"}, 64'(last_ovf[0]), 64'(xo));
        chk({tag, "_zero"}, 64'(last_zero[0]), 64'(xz));
    endtask

    task automatic rand_run(input int d, input int n);
        logic [63:0] m, ra, rb;
        logic        rc, rs, pend, got;
        int          acc, cycles;
        m = (64'd1 << width_of(d)) - 64'd1;
        acc = 0; cycles = 0; pend = 1'b0;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        while (acc < n && cycles < 80000) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                ra = {$urandom, $urandom} & m;
                rb = {$urandom, $urandom} & m;
                if ($urandom_range(0, 15) == 0) ra = m;
                if ($urandom_range(0, 15) == 0) rb = ($urandom_range(0, 1) != 0) ? m : 64'd0;
                rc = $urandom_range(0, 1) != 0;
                rs = $urandom_range(0, 1) != 0;
            end
            step(d, pend, ra, rb, rc, rs, $urandom_range(0, 3) != 0, 1'b0, got);
            if (got) begin
                acc++;
                pend = 1'b0;
            end
            cycles++;
        end
        chk($sformatf("d%0d_rand_accepted", d), 64'(acc), 64'(n));
        drain(d);
    endtask

    task automatic directed;
        logic got;
        int   idx, p0, cycles;
        logic [63:0] da [8];
        logic [63:0] db [8];

        reset_dut(0);

        lat_chk[0] = 1'b1;
        dir_test("add_small", 64'h0005, 64'h0003, 1'b0, 1'b0, 64'h0008, 1'b0, 1'b0, 1'b0);
        lat_chk[0] = 1'b0;
        dir_test("add_wrap", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1);
        dir_test("sub_ovf", 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0);
        dir_test("sub_borrow", 64'h0000, 64'h0001, 1'b0, 1'b1, 64'hFFFF, 1'b0, 1'b0, 1'b0);
        dir_test("add_cin", 64'h7FFF, 64'h0000, 1'b1, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0);

        // Eight back-to-back alternating ADD/SUB with the consumer stalled in cycles 5-7.
        for (int i = 0; i < 8; i++) begin
            da[i] = 64'($urandom_range(0, 65535));
            db[i] = 64'($urandom_range(0, 65535));
        end
        p0 = n_pop[0]; idx = 0; cycles = 0;
        while (cycles < 40 && (idx < 8 || q0.size() != 0)) begin
            if (idx < 8)
                step(0, 1'b1, da[idx], db[idx], idx[1], idx[0], !(cycles >= 5 && cycles <= 7),
                     1'b0, got);
            else
                step(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, got);
            if (got) idx++;
            cycles++;
        end
        chk("b2b_accepted", 64'(idx), 64'd8);
        chk("b2b_results", 64'(n_pop[0] - p0), 64'd8);

        // Reset with three transactions in flight and a fourth offered during reset.
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 64'h1000 + 64'(i), 64'h0101, 1'b0, 1'b0, 1'b1, 1'b0, got);
        step(0, 1'b1, 64'h0AAA, 64'h0555, 1'b0, 1'b0, 1'b1, 1'b1, got);
        idle(0);
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_in_ready", 64'(ir[0]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            idle(0);
            chk("midrst_no_stale", 64'(ov[0]), 64'd0);
        end
        dir_test("post_rst", 64'h1234, 64'h1111, 1'b0, 1'b0, 64'h2345, 1'b0, 1'b0, 1'b0);

        rand_run(0, 10000);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rsti[d] = 1'b1; ivi[d] = 1'b0; cini[d] = 1'b0; subi[d] = 1'b0;
            ordy[d] = 1'b1; ai[d] = '0; bi[d] = '0;
            n_pop[d] = 0; lat_chk[d] = 1'b0; stall_prev[d] = 1'b0; held_sum[d] = '0;
            last_sum[d] = '0; last_cout[d] = 1'b0; last_ovf[d] = 1'b0; last_zero[d] = 1'b0;
        end
        fork
            directed();
            begin
                reset_dut(1);
                rand_run(1, 10000);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have parameter GRP_PER_STAGE, default 1, number of 4-bit lookahead groups resolved per pipeline stage; must divide WIDTH/4.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, operand set present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts the operand set this cycle.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH bits each, the operands.
REQ-008 SHALL have port in_cin, input, 1 bit, carry-in (ADD) or borrow-in (SUB).
REQ-009 SHALL have port in_sub, input, 1 bit, 0 = ADD, 1 = SUB.
REQ-010 SHALL have port out_valid, output, 1 bit, result present.
REQ-011 SHALL have port out_ready, input, 1 bit, consumer takes the result.
REQ-012 SHALL have port out_sum, output, WIDTH bits, the result.
REQ-013 SHALL have port out_cout, output, 1 bit, carry-out (ADD) or not-borrow (SUB).
REQ-014 SHALL have ports out_ovf and out_zero, output, 1 bit each, signed overflow flag and result==0 flag.

Function
REQ-015 SHALL define STAGES = WIDTH/(4*GRP_PER_STAGE); latency from accept to out_valid SHALL be exactly STAGES cycles with no stall.
REQ-016 ADD SHALL compute {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1).
REQ-017 SUB SHALL compute in_a + ~in_b + !in_cin, i.e. in_a - in_b - in_cin; out_cout=1 means no borrow.
REQ-018 Stage k SHALL resolve bits [4*GRP_PER_STAGE*(k+1)-1 : 4*GRP_PER_STAGE*k] with full 4-bit lookahead per group, using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 Operand bits not yet consumed SHALL travel skewed through the pipeline registers; completed sum bits SHALL be de-skewed, so all out_sum bits belong to the same transaction.
REQ-020 out_ovf SHALL be carry-into-MSB XOR carry-out-of-MSB; out_zero SHALL be 1 iff out_sum == 0, regardless of out_cout.
REQ-021 Handshake: transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-022 Global advance SHALL be enable = !out_valid || out_ready; in_ready SHALL equal enable, combinationally.
REQ-023 While enable=0, all stage registers and outputs SHALL hold; in_a/in_b changes SHALL be ignored.
REQ-024 Each stage SHALL carry a valid bit; bubbles SHALL propagate as valid=0 and SHALL NOT be collapsed.
REQ-025 Mode, carry and operands SHALL be captured per transaction; back-to-back mixed ADD/SUB transactions SHALL each produce results for their own mode.
REQ-026 Full throughput of one transaction per cycle SHALL be sustained while out_ready=1.
REQ-027 out_* data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst SHALL clear every stage valid bit, so out_valid=0; in_ready SHALL be 1 in the cycle after reset.
REQ-029 rst SHALL zero out_sum, out_cout, out_ovf, out_zero and all carry/data pipeline registers.
REQ-030 rst asserted mid-operation SHALL discard all in-flight transactions, with no partial result emitted; the input offered in the reset cycle SHALL NOT be accepted.

Structure
REQ-031 Package cla_pkg SHALL hold GROUP_W=4 and mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-032 SHALL instantiate sub-module cla_group4 (inputs a[3:0], b[3:0], cin; outputs s[3:0], cout, grp_p, grp_g), GRP_PER_STAGE times per stage.
REQ-033 Within a stage, groups SHALL chain through cla_group4 group P/G lookahead, not ripple bit-by-bit.

Verification (WIDTH=16, GRP_PER_STAGE=1, so STAGES=4)
REQ-034 Stimulus: ADD a=0x0005, b=0x0003, cin=0. Required response: after 4 cycles, sum=0x0008, cout=0, ovf=0, zero=0.
REQ-035 Stimulus: ADD a=0xFFFF, b=0x0001, cin=0. Required response: sum=0x0000, cout=1, ovf=0, zero=1; this is carry propagation through all 4 stages.
REQ-036 Stimulus: SUB a=0x8000, b=0x0001, cin=0. Required response: sum=0x7FFF, cout=1, ovf=1. Stimulus: SUB a=0x0000, b=0x0001. Required response: sum=0xFFFF, cout=0.
REQ-037 Stimulus: 8 back-to-back transactions with alternating ADD/SUB, and out_ready low for cycles 5-7. Required response: results in order, data stable during the stall, in_ready=0 while stalled, none lost or duplicated.
REQ-038 Stimulus: rst for one cycle with 3 transactions in flight. Required response: out_valid=0 the next cycle, no stale result ever appears, and a new ADD 0x1234+0x1111 gives 0x2345.
REQ-039 Stimulus: random regression of 10k transactions with random valid/ready against a reference model. Required response: zero mismatches; repeat with GRP_PER_STAGE=2 and WIDTH=32.
